reg_writeback: RTL and testbench
================================

REG_WRITEBACK -- requirements
Module: reg_writeback

Interface
REQ-001 Parameter: FIFO_DEPTH, default 2, depth of the long-latency result buffer; power of two, at least 2.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst  in  1  synchronous reset, active-high.
REQ-004 alu_valid  in  1  single-cycle result present this cycle; no backpressure.
REQ-005 alu_rd  in  5  ALU destination register.
REQ-006 alu_data  in  32  ALU result.
REQ-007 lsu_valid  in  1  long-latency (load/multi-cycle) result offered.
REQ-008 lsu_ready  out  1  buffer can accept; a transfer occurs when lsu_valid and lsu_ready are both 1.
REQ-009 lsu_rd  in  5  long-latency destination register.
REQ-010 lsu_data  in  32  long-latency result.
REQ-011 issue_valid  in  1  long-latency op issued this cycle.
REQ-012 issue_rd  in  5  destination of the issued op.
REQ-013 rs1_addr, rs2_addr  in  5 each  decode source operands.
REQ-014 rs1_busy, rs2_busy  out  1 each  combinational scoreboard lookup for the source operands.
REQ-015 RegWrite  out  1  register-file write enable, registered.
REQ-016 WriteAddr  out  5  register-file write address, registered.
REQ-017 WriteData  out  32  register-file write data, registered.

Function
REQ-018 ALU has strict priority: when alu_valid=1 and alu_rd!=0, the next edge sets RegWrite=1, WriteAddr=alu_rd, WriteData=alu_data (latency 1).
REQ-019 An LSU transfer pushes {lsu_rd, lsu_data} into the FIFO; a transfer with lsu_rd=0 is accepted but not pushed.
REQ-020 When the FIFO is non-empty and no ALU write is taken this cycle, the head entry is popped and drives RegWrite/WriteAddr/WriteData at the next edge.
REQ-021 There is no FIFO bypass: an LSU result reaches RegWrite no earlier than 2 cycles after its transfer.
REQ-022 When neither source writes, RegWrite=0 at the next edge; WriteAddr and WriteData hold their previous values.
REQ-023 lsu_ready = !full, and lsu_ready=0 while rst=1; a push and a pop in the same cycle are allowed when the FIFO is non-empty, and count is unchanged.
REQ-024 Read and write pointers wrap modulo FIFO_DEPTH; count ranges from 0 to FIFO_DEPTH; full when count==FIFO_DEPTH; empty when count==0.
REQ-025 An ALU request with alu_rd=0 never asserts RegWrite and does not block the FIFO pop that cycle.
REQ-026 Scoreboard busy[31:0]: issue_valid with issue_rd!=0 sets busy[issue_rd] at the next edge; busy[0] is constantly 0.
REQ-027 A FIFO pop clears busy[popped rd] at the same edge that asserts RegWrite for it.
REQ-028 When a set and a clear hit the same register in the same cycle, the set wins.
REQ-029 rsN_busy = busy[rsN_addr], with no forwarding of same-cycle sets or clears.
REQ-030 An ALU write to a register whose busy bit is set is a protocol violation; a simulation assertion flags it.

Reset
REQ-031 With rst=1 at an edge: RegWrite=0, WriteAddr=0, WriteData=0, FIFO empty (pointers and count 0), busy=0.
REQ-032 Reset mid-operation discards buffered entries and does not write them.
REQ-033 All inputs are ignored in any cycle where rst=1.

Structure
REQ-034 Shared package holds XLEN=32, REG_ADDR_W=5, NUM_REGS=32, and the writeback entry type {rd, data}.
REQ-035 The FIFO is a sub-module, wb_fifo, parameterised by depth and entry width; scoreboard and arbitration stay in reg_writeback.

Verification
REQ-036 alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF -> next cycle RegWrite=1, WriteAddr=5, WriteData=0xDEADBEEF.
REQ-037 issue rd=7, then LSU transfer rd=7, data=0x1234 with ALU idle -> RegWrite at transfer+2 with addr 7, data 0x1234; rs1_addr=7 shows busy=1 until that edge, then 0.
REQ-038 Three LSU transfers with ALU busy every cycle, FIFO_DEPTH=2 -> lsu_ready=0 after two pushes; entries are written in order once the ALU idles.
REQ-039 alu_rd=0 with FIFO head rd=3 -> RegWrite=1, WriteAddr=3 (FIFO pops); an LSU transfer with rd=0 -> no write and count unchanged.
REQ-040 Issue of rd=9 in the same cycle as a pop of rd=9 -> busy[9]=1 afterwards.
REQ-041 rst pulse with 2 entries buffered and busy set -> no RegWrite afterwards, busy=0, lsu_ready=1 the cycle after rst deasserts.

Source files
------------

// File: rtl/reg_writeback_pkg.sv
// ---------------------------------------------------------------------------
// reg_writeback_pkg : shared widths and the writeback entry type
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package reg_writeback_pkg;
    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

    localparam int WB_ENTRY_W = $bits(wb_entry_t);
endpackage

`default_nettype wire

// File: rtl/wb_fifo.sv
// ---------------------------------------------------------------------------
// wb_fifo : power-of-two depth FIFO buffering long-latency writeback entries
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module wb_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 37
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (do_push && !do_pop)      count <= count + CNT_W'(1);
            else if (do_pop && !do_push) count <= count - CNT_W'(1);
        end
    end
endmodule

`default_nettype wire

// File: rtl/reg_writeback.sv
// ---------------------------------------------------------------------------
// reg_writeback : ALU / long-latency writeback arbiter with busy scoreboard
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module reg_writeback
    import reg_writeback_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]       alu_data,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [REG_ADDR_W-1:0] lsu_rd,
    input  logic [XLEN-1:0]       lsu_data,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    output logic                  RegWrite,
    output logic [REG_ADDR_W-1:0] WriteAddr,
    output logic [XLEN-1:0]       WriteData
);
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_next;
    wb_entry_t           head;
    wb_entry_t           push_entry;
    logic                fifo_full;
    logic                fifo_empty;
    logic                alu_take;
    logic                push;
    logic                pop;

    assign lsu_ready  = !fifo_full && !rst;
    assign alu_take   = alu_valid && (alu_rd != '0);
    assign push       = lsu_valid && lsu_ready && (lsu_rd != '0);
    assign pop        = !rst && !fifo_empty && !alu_take;
    assign push_entry = '{rd: lsu_rd, data: lsu_data};

    wb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (WB_ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign rs1_busy = busy[rs1_addr];
    assign rs2_busy = busy[rs2_addr];

    // Clear is applied before set so a same-cycle issue to the popped rd wins.
    always_comb begin
        busy_next = busy;
        if (pop) busy_next[head.rd] = 1'b0;
        if (issue_valid) busy_next[issue_rd] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy      <= '0;
            RegWrite  <= 1'b0;
            WriteAddr <= '0;
            WriteData <= '0;
        end else begin
            busy <= busy_next;
            if (alu_take) begin
                RegWrite  <= 1'b1;
                WriteAddr <= alu_rd;
                WriteData <= alu_data;
            end else if (pop) begin
                RegWrite  <= 1'b1;
                WriteAddr <= head.rd;
                WriteData <= head.data;
            end else begin
                RegWrite  <= 1'b0;
            end
        end
    end

    alu_write_to_busy_reg: assert property (
        @(posedge clk) disable iff (rst) !(alu_take && busy[alu_rd])
    );
endmodule

`default_nettype wire

// File: tb/tb_reg_writeback.sv
// ---------------------------------------------------------------------------
// tb_reg_writeback : directed vector table plus randomized model comparison
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_reg_writeback;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        RegWrite;
    logic [4:0]  WriteAddr;
    logic [31:0] WriteData;

    always #5 clk = ~clk;

    reg_writeback #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .RegWrite(RegWrite), .WriteAddr(WriteAddr), .WriteData(WriteData)
    );

    typedef struct {
        logic        rst;
        logic        av;
        logic [4:0]  ard;
        logic [31:0] adata;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ldata;
        logic        iv;
        logic [4:0]  ird;
        logic [4:0]  rs1;
        logic        e_ready;
        logic        e_busy;
        logic        e_rw;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
    } vec_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    int compared   = 0;
    int mismatched = 0;

    vec_t        vt[26];
    ent_t        q[$];
    logic [31:0] mbusy;
    logic        m_rw;
    logic [4:0]  m_addr;
    logic [31:0] m_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic av, input logic [4:0] ard,
                                input logic [31:0] adata, input logic lv, input logic [4:0] lrd,
                                input logic [31:0] ldata, input logic iv, input logic [4:0] ird,
                                input logic [4:0] rs1, input logic er, input logic eb,
                                input logic erw, input logic [4:0] ea, input logic [31:0] ed);
        vec_t v;
        v.rst = r; v.av = av; v.ard = ard; v.adata = adata;
        v.lv = lv; v.lrd = lrd; v.ldata = ldata; v.iv = iv; v.ird = ird; v.rs1 = rs1;
        v.e_ready = er; v.e_busy = eb; v.e_rw = erw; v.e_addr = ea; v.e_data = ed;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        rst = v.rst; alu_valid = v.av; alu_rd = v.ard; alu_data = v.adata;
        lsu_valid = v.lv; lsu_rd = v.lrd; lsu_data = v.ldata;
        issue_valid = v.iv; issue_rd = v.ird; rs1_addr = v.rs1; rs2_addr = v.rs1;
    endtask

    initial begin
        //          rst av ard adata         lv lrd ldata        iv ird rs1  rdy bsy rw addr data
        vt[0]  = mk(1, 1, 4, 32'h0000_0044, 1, 6, 32'h66,       1, 4, 4,   0, 0, 0, 0,  32'h0);
        vt[1]  = mk(0, 1, 5, 32'hDEAD_BEEF, 0, 0, 32'h0,        0, 0, 7,   1, 0, 1, 5,  32'hDEAD_BEEF);
        vt[2]  = mk(0, 0, 0, 32'h0,         0, 0, 32'h0,        1, 7, 7,   1, 0, 0, 5,  32'hDEAD_BEEF);
        vt[3]  = mk(0, 0, 0, 32'h0,         1, 7, 32'h1234,     0, 0, 7,   1, 1, 0, 5,  32'hDEAD_BEEF);
        vt[4]  = mk(0, 0, 0, 32'h0,         0, 0, 32'h0,        0, 0, 7,   1, 1, 1, 7,  32'h1234);
        vt[5]  = mk(0, 0, 0, 32'h0,         0, 0, 32'h0,        0, 0, 7,   1, 0, 0, 7,  32'h1234);
        vt[6]  = mk(0, 0, 0, 32'h0,         1, 3, 32'h33,       0, 0, 3,   1, 0, 0, 7,  32'h1234);
        vt[7]  = mk(0, 1, 0, 32'hFFFF,      1, 0, 32'h55,       0, 0, 3,   1, 0, 1, 3,  32'h33);
        vt[8]  = mk(0, 0, 0, 32'h0,         0, 0, 32'h0,        0, 0, 3,   1, 0, 0, 3,  32'h33);
        vt[9]  = mk(0, 0, 0, 32'h0,         0, 0, 32'h0,        1, 9, 9,   1, 0, 0, 3,  32'h33);
        vt[10] = mk(0, 0, 0, 32'h0,         1, 9, 32'h99,       0, 0, 9,   1, 1, 0, 3,  32'h33);
        vt[11] = mk(0, 0, 0, 32'h0,         0, 0, 32'h0,        1, 9, 9,   1, 1, 1, 9,  32'h99);
        vt[12] = mk(0, 0, 0, 32'h0,         0, 0, 32'h0,        0, 0, 9,   1, 1, 0, 9,  32'h99);
        vt[13] = mk(0, 1, 1, 32'hA1,        1, 10, 32'h100,     0, 0, 9,   1, 1, 1, 1,  32'hA1);
        vt[14] = mk(0, 1, 2, 32'hA2,        1, 11, 32'h101,     0, 0, 9,   1, 1, 1, 2,  32'hA2);
        vt[15] = mk(0, 1, 3, 32'hA3,        1, 12, 32'h102,     0, 0, 9,   0, 1, 1, 3,  32'hA3);
        vt[16] = mk(0, 1, 4, 32'hA4,        1, 12, 32'h102,     0, 0, 9,   0, 1, 1, 4,  32'hA4);
        vt[17] = mk(0, 0, 0, 32'h0,         1, 12, 32'h102,     0, 0, 9,   0, 1, 1, 10, 32'h100);
        vt[18] = mk(0, 0, 0, 32'h0,         1, 12, 32'h102,     0, 0, 9,   1, 1, 1, 11, 32'h101);
        vt[19] = mk(0, 0, 0, 32'h0,         0, 0, 32'h0,        0, 0, 9,   1, 1, 1, 12, 32'h102);
        vt[20] = mk(0, 0, 0, 32'h0,         0, 0, 32'h0,        0, 0, 9,   1, 1, 0, 12, 32'h102);
        vt[21] = mk(0, 1, 1, 32'h1,         1, 21, 32'h211,     1, 20, 20, 1, 0, 1, 1,  32'h1);
        vt[22] = mk(0, 1, 2, 32'h2,         1, 22, 32'h222,     0, 0, 20,  1, 1, 1, 2,  32'h2);
        vt[23] = mk(1, 0, 0, 32'h0,         0, 0, 32'h0,        0, 0, 20,  0, 1, 0, 0,  32'h0);
        vt[24] = mk(0, 0, 0, 32'h0,         0, 0, 32'h0,        0, 0, 20,  1, 0, 0, 0,  32'h0);
        vt[25] = mk(0, 0, 0, 32'h0,         0, 0, 32'h0,        0, 0, 20,  1, 0, 0, 0,  32'h0);

        drive(vt[0]);
        @(posedge clk); #1;

        for (int i = 0; i < 26; i++) begin
            drive(vt[i]);
            #1;
            chk($sformatf("v%0d lsu_ready", i), 32'(lsu_ready), 32'(vt[i].e_ready));
            chk($sformatf("v%0d rs1_busy", i),  32'(rs1_busy),  32'(vt[i].e_busy));
            @(posedge clk); #1;
            chk($sformatf("v%0d RegWrite", i),  32'(RegWrite),  32'(vt[i].e_rw));
            chk($sformatf("v%0d WriteAddr", i), 32'(WriteAddr), 32'(vt[i].e_addr));
            chk($sformatf("v%0d WriteData", i), 32'(WriteData), 32'(vt[i].e_data));
        end

        // Randomized phase against a queue-based behavioural model.
        q.delete(); mbusy = '0; m_rw = 0; m_addr = '0; m_data = '0;
        for (int c = 0; c < 3000; c++) begin
            logic take, pushok;
            ent_t e;
            rst         = (c == 0) || ($urandom_range(0, 149) == 0);
            alu_valid   = ($urandom_range(0, 2) == 0);
            alu_rd      = 5'($urandom_range(0, 15));
            if (mbusy[alu_rd]) alu_rd = 5'd0;
            alu_data    = $urandom;
            lsu_valid   = ($urandom_range(0, 1) == 1);
            lsu_rd      = 5'($urandom_range(0, 15));
            lsu_data    = $urandom;
            issue_valid = ($urandom_range(0, 3) == 0);
            issue_rd    = 5'($urandom_range(0, 15));
            rs1_addr    = 5'($urandom_range(0, 15));
            rs2_addr    = 5'($urandom_range(0, 15));
            #1;
            chk("rnd lsu_ready", 32'(lsu_ready), 32'(!rst && (q.size() < DEPTH)));
            chk("rnd rs1_busy",  32'(rs1_busy),  32'(mbusy[rs1_addr]));
            chk("rnd rs2_busy",  32'(rs2_busy),  32'(mbusy[rs2_addr]));
            if (rst) begin
                q.delete(); mbusy = '0; m_rw = 0; m_addr = '0; m_data = '0;
            end else begin
                take   = alu_valid && (alu_rd != 0);
                pushok = lsu_valid && (q.size() < DEPTH) && (lsu_rd != 0);
                if (take) begin
                    m_rw = 1; m_addr = alu_rd; m_data = alu_data;
                end else if (q.size() > 0) begin
                    e = q.pop_front();
                    m_rw = 1; m_addr = e.rd; m_data = e.data; mbusy[e.rd] = 1'b0;
                end else begin
                    m_rw = 0;
                end
                if (issue_valid && issue_rd != 0) mbusy[issue_rd] = 1'b1;
                if (pushok) begin
                    e.rd = lsu_rd; e.data = lsu_data;
                    q.push_back(e);
                end
            end
            @(posedge clk); #1;
            chk("rnd RegWrite", 32'(RegWrite), 32'(m_rw));
            chk("rnd WriteAddr", 32'(WriteAddr), 32'(m_addr));
            chk("rnd WriteData", WriteData, m_data);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

`default_nettype wire
